uart_ram_arbiter: RTL

- Scheduler that shares one single-port byte RAM between NPORT UART receivers (writers) and NPORT UART transmitters (readers).
- RAM is split into NPORT equal circular buffers, one per port. A byte received on port p is stored in region p and later sent on transmitter p.
- Sits between the receiver/transmitter banks and the on-chip RAM.
- Owns all RAM address, write-enable and read-enable generation, plus per-port buffer pointers and status.

---
 rtl/uart_ram_arbiter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/uart_ram_arbiter.sv
// uart_ram_arbiter
// Shares one single-port byte RAM between NPORT UART receivers and NPORT
// UART transmitters. The RAM is cut into NPORT circular buffers, one per
// port. Bytes received on port p are queued in region p and replayed on
// transmitter p. RX and TX grants alternate when both sides have work, and
// each side uses its own round-robin pointer.

module uart_ram_arbiter #(
    parameter int NPORT      = 10,
    parameter int PW         = 4,
    parameter int DEPTH_LOG2 = 6,
    parameter int ADDRWIDTH  = 10
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [NPORT-1:0]       i_rx_ready,
    input  logic [8*NPORT-1:0]     i_rx_data,
    output logic [NPORT-1:0]       o_rx_read,
    input  logic [NPORT-1:0]       i_tx_busy,
    output logic [NPORT-1:0]       o_tx_write,
    output logic [7:0]             o_tx_data,
    output logic [ADDRWIDTH-1:0]   o_addr,
    output logic [7:0]             o_D,
    input  logic [7:0]             i_D,
    output logic                   o_WE,
    output logic                   o_RE,
    output logic [NPORT-1:0]       o_empty,
    output logic [NPORT-1:0]       o_full,
    output logic [NPORT-1:0]       o_overflow
);

    typedef enum logic [1:0] {IDLE, WRITE, READ, LOAD} state_t;
    typedef enum logic {PH_RX, PH_TX} phase_t;

    state_t              state;
    phase_t              phase;
    logic [PW-1:0]       port;
    logic [PW-1:0]       rx_rr;
    logic [PW-1:0]       tx_rr;
    logic [DEPTH_LOG2:0] wr_ptr [NPORT];
    logic [DEPTH_LOG2:0] rd_ptr [NPORT];

    logic [NPORT-1:0]    empty;
    logic [NPORT-1:0]    full;
    logic [NPORT-1:0]    rxc;
    logic [NPORT-1:0]    txc;
    logic [PW-1:0]       rx_pick;
    logic [PW-1:0]       tx_pick;
    logic                rx_go;
    logic                tx_go;

    // First requesting port at or after 'start', wrapping from NPORT-1 to 0.
    function automatic logic [PW-1:0] rr_pick(input logic [NPORT-1:0] req,
                                              input logic [PW-1:0]    start);
        int   idx;
        logic found;
        rr_pick = '0;
        found   = 1'b0;
        for (int i = 0; i < NPORT; i++) begin
            idx = int'(start) + i;
            if (idx >= NPORT) idx = idx - NPORT;
            if (!found && req[idx]) begin
                found   = 1'b1;
                rr_pick = PW'(idx);
            end
        end
    endfunction

    // Round-robin successor of a port index.
    function automatic logic [PW-1:0] next_port(input logic [PW-1:0] p);
        next_port = (p == PW'(NPORT - 1)) ? '0 : p + 1'b1;
    endfunction

    // Buffer status: pointers carry one extra wrap bit so equal low bits can
    // be told apart as empty (same lap) or full (one lap apart).
    always_comb begin
        empty = '0;
        full  = '0;
        for (int p = 0; p < NPORT; p++) begin
            empty[p] = (wr_ptr[p] == rd_ptr[p]);
            full[p]  = (wr_ptr[p][DEPTH_LOG2] != rd_ptr[p][DEPTH_LOG2]) &&
                       (wr_ptr[p][DEPTH_LOG2-1:0] == rd_ptr[p][DEPTH_LOG2-1:0]);
        end
    end

    assign o_empty = empty;
    assign o_full  = full;

    // Candidate sets and grant decision; RX wins on its phase or when no TX
    // candidate exists, otherwise TX takes its turn.
    always_comb begin
        rxc     = i_rx_ready & ~full;
        txc     = ~i_tx_busy & ~empty;
        rx_pick = rr_pick(rxc, rx_rr);
        tx_pick = rr_pick(txc, tx_rr);
        rx_go   = (rxc != '0) && ((phase == PH_RX) || (txc == '0));
        tx_go   = !rx_go && (txc != '0);
    end

    // RAM read data goes straight to the transmitter during LOAD only.
    assign o_tx_data = (state == LOAD) ? i_D : 8'h00;

    // Main scheduler: grants in IDLE, performs one RAM access per transfer,
    // and advances the pointer only when the transfer completes.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state      <= IDLE;
            phase      <= PH_RX;
            port       <= '0;
            rx_rr      <= '0;
            tx_rr      <= '0;
            o_WE       <= 1'b0;
            o_RE       <= 1'b0;
            o_addr     <= '0;
            o_D        <= 8'h00;
            o_rx_read  <= '0;
            o_tx_write <= '0;
            for (int p = 0; p < NPORT; p++) begin
                wr_ptr[p] <= '0;
                rd_ptr[p] <= '0;
            end
        end else begin
            o_WE       <= 1'b0;
            o_RE       <= 1'b0;
            o_addr     <= '0;
            o_D        <= 8'h00;
            o_rx_read  <= '0;
            o_tx_write <= '0;
            case (state)
                IDLE: begin
                    if (rx_go) begin
                        state     <= WRITE;
                        port      <= rx_pick;
                        o_WE      <= 1'b1;
                        o_addr    <= ADDRWIDTH'({rx_pick, wr_ptr[rx_pick][DEPTH_LOG2-1:0]});
                        o_D       <= i_rx_data[rx_pick*8 +: 8];
                        o_rx_read <= {{(NPORT-1){1'b0}}, 1'b1} << rx_pick;
                    end else if (tx_go) begin
                        state  <= READ;
                        port   <= tx_pick;
                        o_RE   <= 1'b1;
                        o_addr <= ADDRWIDTH'({tx_pick, rd_ptr[tx_pick][DEPTH_LOG2-1:0]});
                    end
                end
                WRITE: begin
                    wr_ptr[port] <= wr_ptr[port] + 1'b1;
                    rx_rr        <= next_port(port);
                    phase        <= PH_TX;
                    state        <= IDLE;
                end
                READ: begin
                    o_tx_write <= {{(NPORT-1){1'b0}}, 1'b1} << port;
                    state      <= LOAD;
                end
                LOAD: begin
                    rd_ptr[port] <= rd_ptr[port] + 1'b1;
                    tx_rr        <= next_port(port);
                    phase        <= PH_RX;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Sticky overflow: a receiver was holding a byte its full region could not take.
    always_ff @(posedge i_clk) begin
        if (!i_rst) o_overflow <= '0;
        else        o_overflow <= o_overflow | (i_rx_ready & full);
    end

endmodule
